// File: rtl/inj_port_arbiter.sv
// Round-robin arbiter sharing one router local injection port between NUM_REQ
// traffic generators, with wormhole packet locking and a stall watchdog.
package router_pkg;
    localparam int FLIT_SIZE    = 16;
    localparam int NUM_OF_FLITS = 8;

    typedef enum logic [1:0] {
        NONE_FLIT = 2'b00,
        HEAD_FLIT = 2'b01,
        BODY_FLIT = 2'b10,
        TAIL_FLIT = 2'b11
    } FLIT_TYPE_t;
endpackage

module inj_port_arbiter
    import router_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int TIMEOUT       = 64,
    parameter int MAX_PKT_FLITS = NUM_OF_FLITS
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_REQ-1:0]                 i_req,
    output logic [NUM_REQ-1:0]                 o_grant,
    input  logic [NUM_REQ*FLIT_SIZE-1:0]       i_flit,
    output logic [FLIT_SIZE-1:0]               o_flit,
    input  logic [$clog2(MAX_PKT_FLITS):0]     i_space,
    output logic                               o_busy,
    output logic                               o_timeout,
    output logic [$clog2(NUM_REQ)-1:0]         o_owner
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = OW + 1;
    localparam int SW = $clog2(MAX_PKT_FLITS) + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        STREAM  = 2'b10,
        RELEASE = 2'b11
    } state_t;

    state_t                 state_r, state_s;
    logic [OW-1:0]          ptr_r, ptr_s;
    logic [WW-1:0]          wd_r, wd_s;
    logic [NUM_REQ-1:0]     grant_s;
    logic                   busy_s;
    logic                   timeout_s;
    logic [OW-1:0]          owner_s;
    logic [FLIT_SIZE-1:0]   flit_s;

    logic                   pick_found_s;
    logic [OW-1:0]          pick_idx_s;
    logic [FLIT_SIZE-1:0]   owner_flit_s;
    logic                   owner_valid_s;
    FLIT_TYPE_t             owner_type_s;

    function automatic logic [OW-1:0] ptr_after(input logic [OW-1:0] idx);
        if (idx == OW'(NUM_REQ - 1)) begin
            return '0;
        end else begin
            return idx + OW'(1);
        end
    endfunction

    assign owner_flit_s  = i_flit[int'(o_owner)*FLIT_SIZE +: FLIT_SIZE];
    assign owner_valid_s = owner_flit_s[FLIT_SIZE-1];
    assign owner_type_s  = FLIT_TYPE_t'(owner_flit_s[FLIT_SIZE-2 -: 2]);

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin : rr_pick
        logic [CW-1:0] cand;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_r} + CW'(i);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end else begin
                cand = cand;
            end
            if (!pick_found_s && i_req[cand[OW-1:0]]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand[OW-1:0];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state and next-output logic; outputs reflect the state being entered.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        wd_s      = wd_r;
        grant_s   = o_grant;
        busy_s    = o_busy;
        owner_s   = o_owner;
        flit_s    = '0;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                grant_s = '0;
                busy_s  = 1'b0;
                wd_s    = '0;
                if (pick_found_s && (i_space >= SW'(MAX_PKT_FLITS))) begin
                    state_s = GRANT;
                    grant_s = NUM_REQ'(1) << pick_idx_s;
                    busy_s  = 1'b1;
                    owner_s = pick_idx_s;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT, STREAM: begin
                flit_s = owner_valid_s ? owner_flit_s : '0;
                if (owner_valid_s) begin
                    wd_s = '0;
                    if ((state_r == STREAM) && (owner_type_s == TAIL_FLIT)) begin
                        state_s = RELEASE;
                        grant_s = '0;
                        busy_s  = 1'b0;
                    end else begin
                        state_s = STREAM;
                    end
                end else if (wd_r == WW'(TIMEOUT - 1)) begin
                    // Stalled owner: release without the RELEASE bubble.
                    state_s   = IDLE;
                    timeout_s = 1'b1;
                    grant_s   = '0;
                    busy_s    = 1'b0;
                    wd_s      = '0;
                    ptr_s     = ptr_after(o_owner);
                end else begin
                    wd_s = wd_r + WW'(1);
                end
            end
            RELEASE: begin
                state_s = IDLE;
                grant_s = '0;
                busy_s  = 1'b0;
                ptr_s   = ptr_after(o_owner);
            end
            default: begin
                state_s = IDLE;
                grant_s = '0;
                busy_s  = 1'b0;
                wd_s    = '0;
            end
        endcase
    end

    // State, pointer, watchdog and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            wd_r      <= '0;
            o_grant   <= '0;
            o_busy    <= 1'b0;
            o_owner   <= '0;
            o_flit    <= '0;
            o_timeout <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            wd_r      <= wd_s;
            o_grant   <= grant_s;
            o_busy    <= busy_s;
            o_owner   <= owner_s;
            o_flit    <= flit_s;
            o_timeout <= timeout_s;
        end
    end

endmodule
